ov7670_grid_sampler: RTL

//   Parametrised successor to the fixed 3x3 OV7670 capture datapath. It arms on request and

---
 rtl/ov7670_grid_sampler.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ov7670_grid_sampler.sv
// OV7670 RGB565 capture that box-averages short horizontal runs at the points of a
// sampling grid and holds the results in a small register file for the classifier.
module ov7670_grid_sampler #(
    parameter int GRID_ROWS = 3,
    parameter int GRID_COLS = 3,
    parameter int ROW0      = 32,
    parameter int ROW_STEP  = 47,
    parameter int COL0      = 65,
    parameter int COL_STEP  = 84,
    parameter int AVG_LOG2  = 2,
    parameter int LINE_W    = 8,
    parameter int COL_W     = 9,
    parameter int XCLK_DIV  = 2,
    parameter int ADDR_W    = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              VSYNC,
    input  logic              HREF,
    input  logic              PCLK,
    input  logic [7:0]        D,
    output logic              XCLK,
    output logic              busy,
    output logic              frame_done,
    output logic              complete,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [15:0]       rd_data
);

    localparam int NPTS = GRID_ROWS * GRID_COLS;
    localparam int NAVG = 1 << AVG_LOG2;
    localparam int RW   = 5 + AVG_LOG2;
    localparam int GW   = 6 + AVG_LOG2;
    localparam int XW   = $clog2(XCLK_DIV) + 1;

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

    state_t state, state_next;
    logic   start_ok;

    logic [1:0] vsync_sync, href_sync, pclk_sync;
    logic [7:0] d_sync1, d_sync2;
    logic       vsync_d, href_d, pclk_d;
    logic       vsync_fall, vsync_rise, href_fall, pclk_rise, href_s;

    logic        phase, pix_valid;
    logic [7:0]  hi_byte;
    logic [15:0] pixel;
    logic [LINE_W-1:0] line;
    logic [COL_W-1:0]  col;

    logic   row_hit, col_hit, first, last, do_write;
    int     row_idx, col_idx, wr_pt;

    logic [RW-1:0] r_sum, b_sum, r_next, b_next;
    logic [GW-1:0] g_sum, g_next;
    logic [15:0]   wr_data;

    logic [15:0]      mem [NPTS];
    logic [NPTS-1:0]  written;
    logic [XW-1:0]    xclk_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vsync_sync <= '0;
            href_sync  <= '0;
            pclk_sync  <= '0;
            d_sync1    <= '0;
            d_sync2    <= '0;
            vsync_d    <= 1'b0;
            href_d     <= 1'b0;
            pclk_d     <= 1'b0;
        end else begin
            vsync_sync <= {vsync_sync[0], VSYNC};
            href_sync  <= {href_sync[0], HREF};
            pclk_sync  <= {pclk_sync[0], PCLK};
            d_sync1    <= D;
            d_sync2    <= d_sync1;
            vsync_d    <= vsync_sync[1];
            href_d     <= href_sync[1];
            pclk_d     <= pclk_sync[1];
        end
    end

    assign href_s     = href_sync[1];
    assign pclk_rise  = pclk_sync[1] & ~pclk_d;
    assign href_fall  = ~href_s & href_d;
    assign vsync_fall = ~vsync_sync[1] & vsync_d;
    assign vsync_rise = vsync_sync[1] & ~vsync_d;

    // Two bytes per pixel; phase restarts at every line so a glitched line cannot skew the next.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase     <= 1'b0;
            pix_valid <= 1'b0;
            hi_byte   <= '0;
            pixel     <= '0;
        end else begin
            pix_valid <= 1'b0;
            if (!href_s) begin
                phase <= 1'b0;
            end else if (pclk_rise) begin
                phase <= ~phase;
                if (!phase) begin
                    hi_byte <= d_sync2;
                end else begin
                    pixel     <= {hi_byte, d_sync2};
                    pix_valid <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col  <= '0;
            line <= '0;
        end else begin
            if (href_fall)
                col <= '0;
            else if (pix_valid && col != '1)
                col <= col + 1'b1;
            if (vsync_fall)
                line <= '0;
            else if (href_fall && line != '1)
                line <= line + 1'b1;
        end
    end

    always_comb begin
        row_hit = 1'b0;
        col_hit = 1'b0;
        first   = 1'b0;
        last    = 1'b0;
        row_idx = 0;
        col_idx = 0;
        for (int r = 0; r < GRID_ROWS; r++) begin
            if (int'(line) == ROW0 + r * ROW_STEP) begin
                row_hit = 1'b1;
                row_idx = r;
            end
        end
        for (int c = 0; c < GRID_COLS; c++) begin
            if (int'(col) >= COL0 + c * COL_STEP && int'(col) < COL0 + c * COL_STEP + NAVG) begin
                col_hit = 1'b1;
                col_idx = c;
                first   = (int'(col) == COL0 + c * COL_STEP);
                last    = (int'(col) == COL0 + c * COL_STEP + NAVG - 1);
            end
        end
        wr_pt    = row_idx * GRID_COLS + col_idx;
        r_next   = first ? RW'(pixel[15:11]) : r_sum + RW'(pixel[15:11]);
        g_next   = first ? GW'(pixel[10:5])  : g_sum + GW'(pixel[10:5]);
        b_next   = first ? RW'(pixel[4:0])   : b_sum + RW'(pixel[4:0]);
        wr_data  = {r_next[RW-1:AVG_LOG2], g_next[GW-1:AVG_LOG2], b_next[RW-1:AVG_LOG2]};
        do_write = pix_valid && row_hit && col_hit && last && (state == CAPTURE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sum <= '0;
            g_sum <= '0;
            b_sum <= '0;
        end else if (pix_valid && row_hit && col_hit) begin
            r_sum <= r_next;
            g_sum <= g_next;
            b_sum <= b_next;
        end
    end

    // Register file plus per-entry written flags; reads outside the grid return zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NPTS; i++) mem[i] <= '0;
            written <= '0;
            rd_data <= '0;
        end else begin
            if (start_ok) written <= '0;
            for (int i = 0; i < NPTS; i++) begin
                if (do_write && wr_pt == i) begin
                    mem[i]     <= wr_data;
                    written[i] <= 1'b1;
                end
            end
            rd_data <= '0;
            for (int i = 0; i < NPTS; i++) begin
                if (rd_addr == ADDR_W'(i)) rd_data <= mem[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            xclk_cnt <= '0;
            XCLK     <= 1'b0;
        end else if (xclk_cnt == XW'(XCLK_DIV - 1)) begin
            xclk_cnt <= '0;
            XCLK     <= ~XCLK;
        end else begin
            xclk_cnt <= xclk_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            complete <= 1'b0;
        end else begin
            state <= state_next;
            if (start_ok)
                complete <= 1'b0;
            else if (state == CAPTURE && vsync_rise)
                complete <= &written;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        frame_done = 1'b0;
        start_ok   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    start_ok   = 1'b1;
                    state_next = ARM;
                end
            end
            ARM:     if (vsync_fall) state_next = CAPTURE;
            CAPTURE: if (vsync_rise) state_next = DONE;
            DONE: begin
                frame_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
